// File: rtl/mdu.sv
// ---------------------------------------------------------------------------
// mdu -- multiply/divide unit with architectural HI/LO registers.
//
// Runs MULT/MULTU as a 32-step shift-add and DIV/DIVU as a 32-step restoring
// division on operand magnitudes. Signs are applied on the completion edge.
// MTHI/MTLO writes go straight into HI/LO while the unit is idle.
//
// Optional feature macro: MDU_FAST_MUL_EN
//   When defined, MULT/MULTU produce the full product on the accepting edge,
//   so busy is high only in the start cycle. Division is unchanged.
//
// Ports:
//   clk    in  1   clock, rising edge
//   rst    in  1   asynchronous active-high reset
//   start  in  1   one-cycle request to begin the operation selected by op
//   op     in  2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b   in  32  rs / rt operands
//   flush  in  1   cancels any in-flight operation
//   hi_we  in  1   MTHI strobe
//   lo_we  in  1   MTLO strobe
//   wdata  in  32  MTHI/MTLO data
//   busy   out 1   stall request
//   done   out 1   one-cycle pulse after HI/LO are written by an operation
//   hi, lo out 32  architectural HI/LO registers
// ---------------------------------------------------------------------------
module mdu (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic        signed_q;
  logic [31:0] a_q;
  logic        b_sign_q;
  logic        b_zero_q;
  logic [31:0] mag_b;
  // Shared working register: product for MUL, {remainder, dividend/quotient} for DIV.
  logic [63:0] acc;

  logic        accept;
  logic        op_signed;
  logic [31:0] mag_a_in;
  logic [31:0] mag_b_in;
  logic [32:0] mul_sum;
  logic [63:0] mul_nxt;
  logic [63:0] mul_res;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic        q_bit;
  logic [31:0] rem_nxt;
  logic [63:0] div_nxt;
  logic        q_neg;
  logic        r_neg;
  logic [31:0] div_hi;
  logic [31:0] div_lo;

  assign op_signed = ~op[0];
  assign accept    = start && (state == IDLE) && !flush;
  assign busy      = accept || (state != IDLE);

  assign mag_a_in = (op_signed && a[31]) ? -a : a;
  assign mag_b_in = (op_signed && b[31]) ? -b : b;

  // Shift-add step: add the multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole 64-bit register right.
  assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_b} : 33'd0);
  assign mul_nxt = {mul_sum, acc[31:1]};

  // Restoring step: shift the next dividend bit into the remainder and keep
  // the subtraction only when it does not go negative.
  assign div_shift = {acc[63:32], acc[31]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, mag_b};
  assign q_bit     = ~div_diff[33];
  assign rem_nxt   = q_bit ? div_diff[31:0] : div_shift[31:0];
  assign div_nxt   = {rem_nxt, acc[30:0], q_bit};

  // Sign fix-up applied to the final step's output on the completion edge.
  // Divide-by-zero bypasses it and reports all-ones quotient with the
  // untouched dividend as remainder.
  assign q_neg   = signed_q && (a_q[31] ^ b_sign_q);
  assign r_neg   = signed_q && a_q[31];
  assign mul_res = q_neg ? -mul_nxt : mul_nxt;
  assign div_lo  = b_zero_q ? 32'hFFFF_FFFF : (q_neg ? -div_nxt[31:0] : div_nxt[31:0]);
  assign div_hi  = b_zero_q ? a_q : (r_neg ? -div_nxt[63:32] : div_nxt[63:32]);

`ifdef MDU_FAST_MUL_EN
  logic [63:0] fast_prod;
  // Sign-extending both operands to 64 bits makes the low 64 bits of an
  // unsigned multiply equal to the signed product.
  assign fast_prod = {{32{op_signed & a[31]}}, a} * {{32{op_signed & b[31]}}, b};
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; flush wins over both start and completion.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef MDU_FAST_MUL_EN
          state_nxt = op[1] ? DIV : IDLE;
`else
          state_nxt = op[1] ? DIV : MUL;
`endif
        end
      end
      MUL, DIV: begin
        if (flush || cnt == 6'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath, iteration counter and HI/LO registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= 6'd0;
      signed_q <= 1'b0;
      a_q      <= 32'd0;
      b_sign_q <= 1'b0;
      b_zero_q <= 1'b0;
      mag_b    <= 32'd0;
      acc      <= 64'd0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt      <= 6'd32;
            signed_q <= op_signed;
            a_q      <= a;
            b_sign_q <= b[31];
            b_zero_q <= (b == 32'd0);
            mag_b    <= mag_b_in;
            acc      <= {32'd0, mag_a_in};
`ifdef MDU_FAST_MUL_EN
            if (!op[1]) begin
              hi   <= fast_prod[63:32];
              lo   <= fast_prod[31:0];
              done <= 1'b1;
            end
`endif
          end else if (!start) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        MUL, DIV: begin
          if (flush) begin
            cnt <= 6'd0;
          end else begin
            cnt <= cnt - 6'd1;
            acc <= (state == MUL) ? mul_nxt : div_nxt;
            if (cnt == 6'd1) begin
              if (state == MUL) begin
                hi <= mul_res[63:32];
                lo <= mul_res[31:0];
              end else begin
                hi <= div_hi;
                lo <= div_lo;
              end
              done <= 1'b1;
            end
          end
        end
        default: cnt <= 6'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
// ---------------------------------------------------------------------------
// tb_mdu -- self-checking bench for mdu.
//
// Stimulus is driven and outputs sampled on the falling clock edge. Expected
// HI/LO values come from a plain-arithmetic model of MULT/MULTU/DIV/DIVU.
// Latency is counted as rising edges from the start cycle to the first cycle
// in which done is seen high. Honours MDU_FAST_MUL_EN for multiply latency.
// ---------------------------------------------------------------------------
module tb_mdu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        flush = 1'b0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  mdu dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  // Reference result {hi, lo} from ordinary integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int              ix, iy;
    longint          sx, sy, sq, sr;
    longint unsigned ux, uy;
    ix = x;
    iy = y;
    sx = ix;
    sy = iy;
    ux = {32'd0, x};
    uy = {32'd0, y};
    if (!o[1]) begin
      if (!o[0]) begin
        sq = sx * sy;
        return sq;
      end
      return ux * uy;
    end
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (!o[0]) begin
      sq = sx / sy;
      sr = sx % sy;
      return {sr[31:0], sq[31:0]};
    end
    return {32'(ux % uy), 32'(ux / uy)};
  endfunction

  // Issues one operation starting at the current falling edge and returns
  // what was observed; ends on a falling edge one cycle after done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output logic [31:0] ohi, output logic [31:0] olo,
                        output logic busy_gap, output logic busy_end, output logic done_after);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    #1 busy_gap = (busy !== 1'b1);
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    lat   = 1;
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) busy_gap = 1'b1;
      @(negedge clk);
      lat++;
    end
    ohi      = hi;
    olo      = lo;
    busy_end = busy;
    @(negedge clk);
    done_after = done;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({hi, lo} !== 64'd0) begin
      errors++;
      $display("[TB] FAIL reset_hilo got %h_%h expected 0_0", hi, lo);
    end
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_flags got busy=%b done=%b expected 0 0", busy, done);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_div_signed();
    int lat; logic [31:0] rh, rl; logic gap, be, da;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, rh, rl, gap, be, da);
    checks++;
    if ({rh, rl} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      errors++;
      $display("[TB] FAIL div_neg7_by_2 got hi=%h lo=%h expected hi=FFFFFFFF lo=FFFFFFFD", rh, rl);
    end
    checks++;
    if (lat !== DIV_LAT) begin
      errors++;
      $display("[TB] FAIL div_neg7_latency got %0d expected %0d", lat, DIV_LAT);
    end
    checks++;
    if ({gap, be, da} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL div_neg7_handshake got gap=%b busy_at_done=%b done_after=%b expected 0 0 0", gap, be, da);
    end
  endtask

  task automatic test_multu_max();
    int lat; logic [31:0] rh, rl; logic gap, be, da;
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, rh, rl, gap, be, da);
    checks++;
    if ({rh, rl} !== 64'hFFFF_FFFE_0000_0001) begin
      errors++;
      $display("[TB] FAIL multu_max got hi=%h lo=%h expected hi=FFFFFFFE lo=00000001", rh, rl);
    end
    checks++;
    if (lat !== MUL_LAT) begin
      errors++;
      $display("[TB] FAIL multu_latency got %0d expected %0d", lat, MUL_LAT);
    end
    checks++;
    if ({gap, be, da} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL multu_handshake got gap=%b busy_at_done=%b done_after=%b expected 0 0 0", gap, be, da);
    end
  endtask

  task automatic test_div_corners();
    int lat; logic [31:0] rh, rl; logic gap, be, da;
    run_op(OP_DIVU, 32'h1234_5678, 32'd0, lat, rh, rl, gap, be, da);
    checks++;
    if ({rh, rl} !== 64'h1234_5678_FFFF_FFFF || lat !== DIV_LAT) begin
      errors++;
      $display("[TB] FAIL divu_by_zero got hi=%h lo=%h lat=%0d expected hi=12345678 lo=FFFFFFFF lat=%0d", rh, rl, lat, DIV_LAT);
    end
    run_op(OP_DIV, 32'h8765_4321, 32'd0, lat, rh, rl, gap, be, da);
    checks++;
    if ({rh, rl} !== 64'h8765_4321_FFFF_FFFF) begin
      errors++;
      $display("[TB] FAIL div_signed_by_zero got hi=%h lo=%h expected hi=87654321 lo=FFFFFFFF", rh, rl);
    end
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, rh, rl, gap, be, da);
    checks++;
    if ({rh, rl} !== 64'h0000_0000_8000_0000) begin
      errors++;
      $display("[TB] FAIL div_minint_by_m1 got hi=%h lo=%h expected hi=00000000 lo=80000000", rh, rl);
    end
  endtask

  task automatic test_random();
    int lat, exp_lat; logic [31:0] rh, rl, x, y; logic [1:0] o; logic gap, be, da;
    logic [63:0] exp;
    for (int i = 0; i < 16; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(16, 31);
      if ($urandom_range(0, 7) == 0) y = 32'd0;
      exp     = model(o, x, y);
      exp_lat = o[1] ? DIV_LAT : MUL_LAT;
      run_op(o, x, y, lat, rh, rl, gap, be, da);
      checks++;
      if ({rh, rl} !== exp) begin
        errors++;
        $display("[TB] FAIL random_result op=%b a=%h b=%h got %h_%h expected %h", o, x, y, rh, rl, exp);
      end
      checks++;
      if (lat !== exp_lat || {gap, be, da} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL random_timing op=%b got lat=%0d gap=%b busy_at_done=%b done_after=%b expected lat=%0d 0 0 0",
                 o, lat, gap, be, da, exp_lat);
      end
    end
  endtask

  task automatic test_flush();
    int lat; logic [31:0] rh, rl; logic gap, be, da;
    hi_we = 1'b1; wdata = 32'h1111_1111;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h2222_2222;
    @(negedge clk);
    lo_we = 1'b0;
    start = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00 || {hi, lo} !== 64'h1111_1111_2222_2222) begin
      errors++;
      $display("[TB] FAIL flush_cancel got busy=%b done=%b hi=%h lo=%h expected 0 0 11111111 22222222", busy, done, hi, lo);
    end
    // The restart must take a full division time; a leftover completion of
    // the flushed operation would show up as a short latency here.
    run_op(OP_DIVU, 32'd100, 32'd7, lat, rh, rl, gap, be, da);
    checks++;
    if ({rh, rl} !== 64'h0000_0002_0000_000E || lat !== DIV_LAT || gap !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_restart got hi=%h lo=%h lat=%0d gap=%b expected hi=2 lo=E lat=%0d gap=0", rh, rl, lat, gap, DIV_LAT);
    end
  endtask

  task automatic test_move_to_hilo();
    int n;
    hi_we = 1'b1; wdata = 32'hA5A5_0001;
    @(negedge clk);
    hi_we = 1'b0;
    checks++;
    if (hi !== 32'hA5A5_0001) begin
      errors++;
      $display("[TB] FAIL mthi_idle got %h expected A5A50001", hi);
    end
    start = 1'b1; op = OP_DIVU; a = 32'd7; b = 32'd2;
    hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    checks++;
    if (hi !== 32'hA5A5_0001) begin
      errors++;
      $display("[TB] FAIL mthi_with_start got %h expected A5A50001", hi);
    end
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ({hi, lo} !== 64'h0000_0001_0000_0003 || done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL divu_after_mthi got hi=%h lo=%h done=%b expected 1 3 1", hi, lo, done);
    end
    @(negedge clk);
    lo_we = 1'b1; wdata = 32'hCAFE_F00D;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mtlo_busy got %b expected 0", busy);
    end
    @(negedge clk);
    lo_we = 1'b0;
    checks++;
    if (lo !== 32'hCAFE_F00D || hi !== 32'd1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mtlo_write got lo=%h hi=%h busy=%b expected CAFEF00D 1 0", lo, hi, busy);
    end
  endtask

  task automatic test_reset_mid_op();
    int seen;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5555_AAAA;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    start = 1'b1; a = 32'h0001_FFFF; b = 32'h0000_FFFF;
`ifdef MDU_FAST_MUL_EN
    op = OP_DIVU;
`else
    op = OP_MULTU;
`endif
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({hi, lo} !== 64'd0 || {busy, done} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_mid_op got hi=%h lo=%h busy=%b done=%b expected 0 0 0 0", hi, lo, busy, done);
    end
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("[TB] FAIL reset_no_done got %0d active cycles expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_div_signed();
    test_multu_max();
    test_div_corners();
    test_random();
    test_flush();
    test_move_to_hilo();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
